// File: rtl/spi_master_core.sv
// -----------------------------------------------------------------------------
// spi_master_core
//
// SPI master that runs one command-plus-data frame per accepted request.
// The frame is {cmd, wdata}, shifted out MSB first, while MISO is shifted in
// on the sampling edge. All four CPOL/CPHA modes are supported, with a run-time
// SCLK divider and CS setup / hold / high times counted in sys_clk cycles.
//
// Handshake: a one-cycle 'start' pulse is accepted only while busy=0 and the
// FSM is IDLE. Accept latches every request input, so later input changes do
// not affect the frame. busy stays high from the cycle after accept through
// the CS high (gap) time. 'done' pulses once per completed frame, in the same
// cycle that CS is released and rdata updates. A start with an out-of-range
// cs_sel pulses 'err' for one cycle instead. A start while busy is dropped.
//
// Ports:
//   sys_clk, sys_rst   clock, asynchronous active-high reset
//   start              one-cycle transfer request
//   cmd, wdata         command word and write data, sent as {cmd, wdata}
//   cs_sel             binary chip-select index
//   mode               {CPOL, CPHA}
//   clk_div            SCLK half-period is clk_div+1 sys_clk cycles
//   busy, done, err    status (done/err are one-cycle pulses)
//   rdata              last DATA_WIDTH bits sampled from MISO
//   spi_cs_n           active-low chip selects
//   spi_sclk, spi_mosi, spi_miso   serial bus
//   fsm_state          current FSM state, for debug and checkers
// -----------------------------------------------------------------------------
module spi_master_core #(
  parameter int CMD_WIDTH  = 5,
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 11,
  parameter int CS_NUM     = 2,
  parameter int DIV_WIDTH  = 8,
  parameter int SU_CYC     = 2,
  parameter int HD_CYC     = 2,
  parameter int HI_CYC     = 8,
  localparam int CSW       = (CS_NUM > 1) ? $clog2(CS_NUM) : 1
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic                  start,
  input  logic [CMD_WIDTH-1:0]  cmd,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [CSW-1:0]        cs_sel,
  input  logic [1:0]            mode,
  input  logic [DIV_WIDTH-1:0]  clk_div,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [CS_NUM-1:0]     spi_cs_n,
  output logic                  spi_sclk,
  output logic                  spi_mosi,
  input  logic                  spi_miso,
  output logic [2:0]            fsm_state
);

  localparam int FRAME = CMD_WIDTH + DATA_WIDTH;
  // One timer serves setup, SCLK half-period, hold and gap counting.
  localparam int TW    = (DIV_WIDTH > 16) ? DIV_WIDTH : 16;
  localparam int EW    = $clog2(2 * FRAME) + 1;
  localparam logic [CSW:0] CS_LIMIT = (CSW + 1)'(CS_NUM);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SETUP = 3'd1;
  localparam logic [2:0] ST_SHIFT = 3'd2;
  localparam logic [2:0] ST_HOLD  = 3'd3;
  localparam logic [2:0] ST_GAP   = 3'd4;

  // The address field lives in the LSBs of cmd, so it cannot be wider than
  // cmd; the timing counts must be at least one cycle.
  if (ADDR_WIDTH > CMD_WIDTH || SU_CYC < 1 || HD_CYC < 1 || HI_CYC < 1) begin : g_bad_param
    $error("spi_master_core: illegal parameter set");
  end

  logic [2:0]            state;
  logic [FRAME-1:0]      tx_sr;
  logic [DATA_WIDTH-1:0] rx_sr;
  logic                  cpha_q;
  logic [DIV_WIDTH-1:0]  div_q;
  logic [TW-1:0]         tmr;
  logic [EW-1:0]         edge_cnt;

  logic [FRAME-1:0]      frame_in;
  logic                  sel_ok;
  logic                  fire;
  logic                  leading;
  logic                  last_edge;

  assign frame_in  = {cmd, wdata};
  assign sel_ok    = ({1'b0, cs_sel} < CS_LIMIT);
  // An SCLK edge is produced whenever the timer expires in SETUP (the first
  // edge) or in SHIFT (every later edge).
  assign fire      = ((state == ST_SETUP) || (state == ST_SHIFT)) && (tmr == '0);
  // Even edge indices move SCLK away from CPOL, odd ones return it.
  assign leading   = ~edge_cnt[0];
  assign last_edge = (edge_cnt == EW'(2 * FRAME - 1));
  assign fsm_state = state;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state    <= ST_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      rdata    <= '0;
      spi_cs_n <= '1;
      spi_sclk <= 1'b0;
      spi_mosi <= 1'b0;
      tx_sr    <= '0;
      rx_sr    <= '0;
      cpha_q   <= 1'b0;
      div_q    <= '0;
      tmr      <= '0;
      edge_cnt <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;

      case (state)
        ST_IDLE: begin
          spi_sclk <= mode[1];
          if (start) begin
            if (sel_ok) begin
              busy     <= 1'b1;
              state    <= ST_SETUP;
              tmr      <= TW'(SU_CYC - 1);
              edge_cnt <= '0;
              cpha_q   <= mode[0];
              div_q    <= clk_div;
              rx_sr    <= '0;
              for (int i = 0; i < CS_NUM; i++) begin
                spi_cs_n[i] <= (cs_sel != CSW'(i));
              end
              if (!mode[0]) begin
                // CPHA=0: the first bit must already be on MOSI before the
                // first (sampling) edge.
                spi_mosi <= frame_in[FRAME-1];
                tx_sr    <= {frame_in[FRAME-2:0], 1'b0};
              end else begin
                tx_sr    <= frame_in;
              end
            end else begin
              err <= 1'b1;
            end
          end
        end

        ST_SETUP: begin
          if (tmr != '0) begin
            tmr <= tmr - 1'b1;
          end else begin
            state <= ST_SHIFT;
            tmr   <= TW'(div_q);
          end
        end

        ST_SHIFT: begin
          if (tmr != '0) begin
            tmr <= tmr - 1'b1;
          end else if (last_edge) begin
            state <= ST_HOLD;
            tmr   <= TW'(HD_CYC - 1);
          end else begin
            tmr <= TW'(div_q);
          end
        end

        ST_HOLD: begin
          if (tmr != '0) begin
            tmr <= tmr - 1'b1;
          end else begin
            spi_cs_n <= '1;
            spi_mosi <= 1'b0;
            done     <= 1'b1;
            rdata    <= rx_sr;
            state    <= ST_GAP;
            tmr      <= TW'(HI_CYC - 1);
          end
        end

        ST_GAP: begin
          if (tmr != '0) begin
            tmr <= tmr - 1'b1;
          end else begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase

      if (fire) begin
        spi_sclk <= ~spi_sclk;
        edge_cnt <= edge_cnt + 1'b1;
        // Sample on leading for CPHA=0, on trailing for CPHA=1. rx_sr is only
        // DATA_WIDTH wide, so command-phase samples fall off the top.
        if (leading ^ cpha_q) begin
          rx_sr <= {rx_sr[DATA_WIDTH-2:0], spi_miso};
        end
        // Drive on the opposite edge; CPHA=0 does not shift after the last bit.
        if ((leading == cpha_q) && !last_edge) begin
          spi_mosi <= tx_sr[FRAME-1];
          tx_sr    <= {tx_sr[FRAME-2:0], 1'b0};
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_master_core.sv
// -----------------------------------------------------------------------------
// tb_spi_master_core
//
// Directed bench for spi_master_core with default parameters, plus a second
// instance with CS_NUM=3 so an out-of-range cs_sel can be expressed.
// -----------------------------------------------------------------------------
module tb_spi_master_core;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- main DUT ----------------
  logic        start = 1'b0;
  logic [4:0]  cmd = '0;
  logic [10:0] wdata = '0;
  logic        cs_sel = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic [7:0]  clk_div = '0;
  logic        busy, done, err;
  logic [10:0] rdata;
  logic [1:0]  spi_cs_n;
  logic        spi_sclk, spi_mosi, spi_miso;
  logic [2:0]  fsm_state;

  spi_master_core u_dut (
    .sys_clk(clk), .sys_rst(rst), .start(start), .cmd(cmd), .wdata(wdata),
    .cs_sel(cs_sel), .mode(mode), .clk_div(clk_div), .busy(busy), .done(done),
    .err(err), .rdata(rdata), .spi_cs_n(spi_cs_n), .spi_sclk(spi_sclk),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso), .fsm_state(fsm_state)
  );

  // ---------------- three-CS instance for rejection ----------------
  logic        start3 = 1'b0;
  logic [1:0]  cs_sel3 = '0;
  logic        busy3, done3, err3;
  logic [10:0] rdata3;
  logic [2:0]  cs3;
  logic        sclk3, mosi3;
  logic [2:0]  state3;

  spi_master_core #(.CS_NUM(3)) u_dut3 (
    .sys_clk(clk), .sys_rst(rst), .start(start3), .cmd(5'h15), .wdata(11'h0AA),
    .cs_sel(cs_sel3), .mode(2'b00), .clk_div(8'd0), .busy(busy3), .done(done3),
    .err(err3), .rdata(rdata3), .spi_cs_n(cs3), .spi_sclk(sclk3),
    .spi_mosi(mosi3), .spi_miso(1'b0), .fsm_state(state3)
  );

  // ---------------- scoreboard counters and checker ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  // ---------------- MISO sources ----------------
  // 0: loopback from MOSI, 1: tied high, 2: slave model
  logic [1:0]  miso_src = 2'd0;
  logic [15:0] s_frame = 16'h02B6;
  logic        mon_cpol = 1'b0;
  logic        mon_cpha = 1'b0;
  int          s_edges = 0;
  int          s_idx;
  logic        slave_bit;

  always @(spi_sclk) if (!(&spi_cs_n)) s_edges = s_edges + 1;
  always @(spi_cs_n) if (&spi_cs_n) s_edges = 0;

  // Slave presents bit k before the k-th sampling edge: CPHA=0 from CS fall
  // and each trailing edge, CPHA=1 on each leading edge.
  always_comb begin
    s_idx = mon_cpha ? (s_edges - 1) / 2 : s_edges / 2;
    if (s_idx < 0 || s_idx > 15) slave_bit = 1'b0;
    else slave_bit = s_frame[15 - s_idx];
  end

  assign spi_miso = (miso_src == 2'd0) ? spi_mosi :
                    (miso_src == 2'd1) ? 1'b1 : slave_bit;

  // ---------------- bus monitor (samples on negedge) ----------------
  int          n_edges, unstable, bad_mosi, hp_min, hp_max, last_edge_cyc;
  int          hi_run = 0, last_gap = 0, done_cnt = 0;
  logic [15:0] mosi_cap;
  logic [1:0]  cs_mask;
  logic        prev_sclk = 1'b0, prev_mosi = 1'b0;
  logic [1:0]  prev_cs = 2'b11;
  logic        sclk_chg, samp;

  task automatic clr_stats();
    n_edges = 0; unstable = 0; bad_mosi = 0; hp_min = 1000; hp_max = 0;
    last_edge_cyc = 0; mosi_cap = '0; cs_mask = '0;
  endtask

  always @(negedge clk) begin
    sclk_chg = (spi_sclk != prev_sclk);
    samp     = mon_cpha ? (spi_sclk == mon_cpol) : (spi_sclk != mon_cpol);
    if (!(&spi_cs_n)) begin
      cs_mask = cs_mask | ~spi_cs_n;
      if (sclk_chg) begin
        if (n_edges > 0) begin
          if (cyc - last_edge_cyc < hp_min) hp_min = cyc - last_edge_cyc;
          if (cyc - last_edge_cyc > hp_max) hp_max = cyc - last_edge_cyc;
        end
        last_edge_cyc = cyc;
        n_edges++;
        if (samp) begin
          mosi_cap = {mosi_cap[14:0], spi_mosi};
          if (spi_mosi != prev_mosi) unstable++;
        end
      end
      // MOSI may only move together with a drive edge once CS is settled.
      if (spi_mosi != prev_mosi && !(&prev_cs) && !(sclk_chg && !samp)) bad_mosi++;
    end
    if (&spi_cs_n) hi_run++;
    else if (hi_run > 0) begin
      last_gap = hi_run;
      hi_run = 0;
    end
    if (done) done_cnt++;
    prev_sclk = spi_sclk;
    prev_mosi = spi_mosi;
    prev_cs   = spi_cs_n;
  end

  // ---------------- driver tasks ----------------
  task automatic wait_idle(input string tag);
    int i;
    for (i = 0; i < 300; i++) begin
      if (!busy) break;
      @(negedge clk);
    end
    if (busy) check({tag, "_idle_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic setup_frame(input logic [4:0] c, input logic [10:0] w, input logic s,
                             input logic [1:0] m, input logic [7:0] d);
    cmd = c; wdata = w; cs_sel = s; mode = m; clk_div = d;
    mon_cpol = m[1]; mon_cpha = m[0];
    clr_stats();
  endtask

  task automatic pulse_start(output int t0);
    start = 1'b1;
    t0 = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int t0, input string tag, output int lat);
    lat = -1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (done) begin
        lat = cyc - t0;
        break;
      end
    end
    if (lat < 0) check({tag, "_done_timeout"}, 32'd0, 32'd1);
  endtask

  // Full frame from idle: set inputs, let IDLE SCLK settle, start, wait done.
  task automatic run_frame(input logic [4:0] c, input logic [10:0] w, input logic s,
                           input logic [1:0] m, input logic [7:0] d,
                           input string tag, output int lat);
    int t0;
    wait_idle(tag);
    setup_frame(c, w, s, m, d);
    @(negedge clk);
    clr_stats();
    pulse_start(t0);
    wait_done(t0, tag, lat);
  endtask

  // ---------------- stimulus ----------------
  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int lat, t0, t1, dc0, act;

    // Reset state, checked before any clock edge.
    #1 rst = 1'b1;
    #1;
    check("rst_flags", {busy, done, err, spi_sclk, spi_mosi, spi_cs_n}, 7'b00000_11);
    check("rst_rdata", rdata, 11'h000);
    check("rst_state", fsm_state, 3'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Mode 0, clk_div=0, loopback.
    miso_src = 2'd0;
    run_frame(5'h13, 11'h5A5, 1'b0, 2'b00, 8'd0, "m0", lat);
    check("m0_latency", lat, 36);
    check("m0_rdata", rdata, 11'h5A5);
    check("m0_mosi", mosi_cap, 16'h9DA5);
    check("m0_cs_mask", cs_mask, 2'b01);
    check("m0_edges", n_edges, 32);
    check("m0_half_period", {hp_min[15:0], hp_max[15:0]}, {16'd1, 16'd1});
    check("m0_mosi_stable", unstable + bad_mosi, 0);

    // Mode 3, clk_div=3, cs_sel=1, MISO tied high.
    miso_src = 2'd1;
    run_frame(5'h0A, 11'h3C3, 1'b1, 2'b11, 8'd3, "m3", lat);
    check("m3_latency", lat, 129);
    check("m3_rdata", rdata, 11'h7FF);
    check("m3_mosi", mosi_cap, 16'h53C3);
    check("m3_cs_mask", cs_mask, 2'b10);
    check("m3_half_period", {hp_min[15:0], hp_max[15:0]}, {16'd4, 16'd4});
    check("m3_mosi_on_fall", unstable + bad_mosi, 0);
    wait_idle("m3");
    check("m3_sclk_idle_high", spi_sclk, 1'b1);

    // Mode 1 and mode 2 against the slave model.
    miso_src = 2'd2;
    s_frame  = 16'h02B6;
    run_frame(5'h1F, 11'h000, 1'b0, 2'b01, 8'd1, "m1", lat);
    check("m1_rdata", rdata, 11'h2B6);
    check("m1_mosi", mosi_cap, 16'hF800);
    check("m1_mosi_stable", unstable + bad_mosi, 0);
    run_frame(5'h01, 11'h7FF, 1'b0, 2'b10, 8'd2, "m2", lat);
    check("m2_rdata", rdata, 11'h2B6);
    check("m2_mosi", mosi_cap, 16'h0FFF);
    check("m2_mosi_stable", unstable + bad_mosi, 0);
    check("m2_half_period", {hp_min[15:0], hp_max[15:0]}, {16'd3, 16'd3});

    // Starts during busy and GAP are dropped; a start on the busy-fall cycle
    // is accepted. cmd is also disturbed mid-frame.
    miso_src = 2'd0;
    wait_idle("ign");
    setup_frame(5'h13, 11'h5A5, 1'b0, 2'b00, 8'd0);
    @(negedge clk);
    clr_stats();
    dc0 = done_cnt;
    pulse_start(t0);
    repeat (5) @(negedge clk);
    cmd = 5'h1F; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(t0, "ign_a", lat);
    check("ign_a_rdata", rdata, 11'h5A5);
    check("ign_a_mosi", mosi_cap, 16'h9DA5);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (!busy) break;
      @(negedge clk);
    end
    setup_frame(5'h0C, 11'h0F0, 1'b0, 2'b00, 8'd0);
    pulse_start(t1);
    wait_done(t1, "ign_b", lat);
    check("ign_b_latency", lat, 36);
    check("ign_b_rdata", rdata, 11'h0F0);
    check("ign_b_mosi", mosi_cap, 16'h60F0);
    check("ign_cs_high_ge8", (last_gap >= 8), 1'b1);
    repeat (60) @(negedge clk);
    check("ign_done_count", done_cnt - dc0, 2);
    check("ign_busy_low", busy, 1'b0);

    // Rejection on the three-CS instance.
    cs_sel3 = 2'd3; start3 = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
    check("rej_err_pulse", {err3, busy3, cs3}, {1'b1, 1'b0, 3'b111});
    @(negedge clk);
    check("rej_err_one_cycle", err3, 1'b0);
    act = 0;
    repeat (20) begin
      @(negedge clk);
      if (sclk3 !== 1'b0 || cs3 !== 3'b111 || busy3 !== 1'b0 || err3 !== 1'b0) act++;
    end
    check("rej_no_activity", act, 0);

    // Reset in the middle of SHIFT bit 7.
    wait_idle("abort");
    setup_frame(5'h13, 11'h5A5, 1'b0, 2'b00, 8'd0);
    @(negedge clk);
    dc0 = done_cnt;
    pulse_start(t0);
    repeat (17) @(negedge clk);
    check("abort_in_shift", fsm_state, 3'd2);
    #2 rst = 1'b1;
    #1;
    check("abort_outputs", {busy, done, err, spi_sclk, spi_mosi, spi_cs_n}, 7'b00000_11);
    check("abort_rdata", rdata, 11'h000);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    check("abort_no_done", done_cnt - dc0, 0);
    run_frame(5'h06, 11'h1E3, 1'b0, 2'b00, 8'd0, "recover", lat);
    check("recover_latency", lat, 36);
    check("recover_rdata", rdata, 11'h1E3);
    check("recover_mosi", mosi_cap, 16'h31E3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
